// File: rtl/mips_mc_control_pkg.sv
// Shared constants for the multicycle MIPS control path: state encodings,
// opcodes, AluOp/AluSrcB/PCSource codes, and the packed control bundle.
package mips_mc_control_pkg;

  localparam logic [3:0] S_RESET  = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_ADDIWB = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Shared with the downstream ALU control decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  // Where DECODE sends each opcode; unknown opcodes trap.
  function automatic logic [3:0] dispatch(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW, OP_ADDI: return S_MEMADR;
      OP_RTYPE:              return S_EXEC;
      OP_BEQ, OP_BNE:        return S_BRANCH;
      OP_J:                  return S_JUMP;
      default:               return S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM: sequences each instruction, drives the
// datapath enables/muxes and AluOp, and counts retired instructions.
module mips_mc_control
  import mips_mc_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             BranchNe,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             AluSrcA,
  output logic [1:0]       AluSrcB,
  output logic [1:0]       AluOp,
  output logic [1:0]       PCSource,
  output logic             illegal_op,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] instr_count
);

  logic [3:0]       state;
  logic [3:0]       state_next;
  ctrl_t            ctrl;
  logic             retire;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RESET;
    else        state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_RESET:  state_next = S_FETCH;
      S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_next = dispatch(Opcode);
      S_MEMADR: begin
        case (Opcode)
          OP_LW:   state_next = S_MEMRD;
          OP_SW:   state_next = S_MEMWR;
          OP_ADDI: state_next = S_ADDIWB;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_next = S_ALUWB;
      default:  state_next = S_FETCH;
    endcase
  end

  // Moore decode; only the FETCH write enables follow mem_ready directly.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.pc_write  = mem_ready;
        ctrl.ir_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
        ctrl.branch_ne     = (Opcode == OP_BNE);
      end
      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      S_TRAP: begin
        ctrl.illegal_op = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // An instruction retires on the edge that leaves its final state.
  always_comb begin
    retire = 1'b0;
    case (state)
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEMWR: retire = mem_ready;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (retire) count <= count + 1'b1;
  end

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign BranchNe    = ctrl.branch_ne;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign AluSrcA     = ctrl.alu_src_a;
  assign AluSrcB     = ctrl.alu_src_b;
  assign AluOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign illegal_op  = ctrl.illegal_op;
  assign state_dbg   = state;
  assign instr_count = count;

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized self-checking bench: each instruction is expanded into its
// per-cycle expected control script and compared cycle by cycle.
module tb_mips_mc_control;
  import mips_mc_control_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [5:0]    Opcode = 6'd0;
  logic          mem_ready = 1'b0;
  logic          PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite;
  logic          IRWrite, MemtoReg, RegDst, RegWrite, AluSrcA, illegal_op;
  logic [1:0]    AluSrcB, AluOp, PCSource;
  logic [3:0]    state_dbg;
  logic [CW-1:0] instr_count;

  logic [CW-1:0] exp_count = '0;
  int            checks = 0;
  int            passed = 0;

  mips_mc_control #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp), .PCSource(PCSource),
    .illegal_op(illegal_op), .state_dbg(state_dbg), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  wire [18:0] obs_ctl = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite,
                         IRWrite, MemtoReg, RegDst, RegWrite, AluSrcA, AluSrcB,
                         AluOp, PCSource, illegal_op};

  function automatic logic [18:0] cv(input bit pcw, pcwc, bne, iord, mr, mw, irw,
                                     m2r, rdst, rw, srca, input logic [1:0] srcb,
                                     aop, pcs, input bit ill);
    return {pcw, pcwc, bne, iord, mr, mw, irw, m2r, rdst, rw, srca, srcb, aop, pcs, ill};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle: drive mem_ready at the falling edge, then check.
  task automatic applyStimulus(input string tag, input logic [3:0] st,
                               input logic [18:0] ctl, input logic ready);
    @(negedge clk);
    mem_ready = ready;
    #1;
    checkOutput({tag, "_state"}, 32'(state_dbg), 32'(st));
    checkOutput({tag, "_ctl"}, 32'(obs_ctl), 32'(ctl));
  endtask

  // Expected script for one instruction, written from its phase sequence.
  task automatic runInstr(input logic [5:0] op, input int fetch_stall, input int mem_stall);
    Opcode = op;
    for (int i = 0; i < fetch_stall; i++)
      applyStimulus("fetch_wait", S_FETCH, cv(0,0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b0);
    applyStimulus("fetch", S_FETCH, cv(1,0,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b1);
    checkOutput("count", 32'(instr_count), 32'(exp_count));
    applyStimulus("decode", S_DECODE, cv(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0),
                  1'($urandom_range(0, 1)));
    case (op)
      OP_LW, OP_SW, OP_ADDI: begin
        applyStimulus("memadr", S_MEMADR, cv(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0),
                      1'($urandom_range(0, 1)));
        if (op == OP_LW) begin
          for (int i = 0; i < mem_stall; i++)
            applyStimulus("memrd_wait", S_MEMRD, cv(0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b0);
          applyStimulus("memrd", S_MEMRD, cv(0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b1);
          applyStimulus("memwb", S_MEMWB, cv(0,0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0), 1'b1);
        end else if (op == OP_SW) begin
          for (int i = 0; i < mem_stall; i++)
            applyStimulus("memwr_wait", S_MEMWR, cv(0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b0);
          applyStimulus("memwr", S_MEMWR, cv(0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b1);
        end else begin
          applyStimulus("addiwb", S_ADDIWB, cv(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0), 1'b1);
        end
        exp_count = exp_count + 1'b1;
      end
      OP_RTYPE: begin
        applyStimulus("exec", S_EXEC, cv(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0), 1'b1);
        applyStimulus("aluwb", S_ALUWB, cv(0,0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0), 1'b1);
        exp_count = exp_count + 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        applyStimulus("branch", S_BRANCH,
                      cv(0,1,(op == OP_BNE),0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0), 1'b1);
        exp_count = exp_count + 1'b1;
      end
      OP_J: begin
        applyStimulus("jump", S_JUMP, cv(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0), 1'b1);
        exp_count = exp_count + 1'b1;
      end
      default:
        applyStimulus("trap", S_TRAP, cv(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1), 1'b1);
    endcase
  endtask

  task automatic holdReset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus("reset", S_RESET, '0, 1'($urandom_range(0, 1)));
      checkOutput("reset_count", 32'(instr_count), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("release_state", 32'(state_dbg), 32'(S_RESET));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL timeout: simulation exceeded time bound");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [5:0] op_list [7];
    logic [5:0] op;
    op_list = '{OP_LW, OP_SW, OP_ADDI, OP_RTYPE, OP_BEQ, OP_BNE, OP_J};

    holdReset(3);
    exp_count = '0;

    runInstr(OP_LW, 0, 0);
    runInstr(OP_RTYPE, 0, 0);
    runInstr(OP_BEQ, 0, 0);
    runInstr(OP_SW, 0, 3);
    runInstr(6'b111111, 0, 0);
    runInstr(OP_BNE, 1, 0);
    runInstr(OP_ADDI, 2, 0);

    // Asynchronous reset in the middle of a load's memory read.
    Opcode = OP_LW;
    applyStimulus("a_fetch", S_FETCH, cv(1,0,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b1);
    applyStimulus("a_decode", S_DECODE, cv(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0), 1'b1);
    applyStimulus("a_memadr", S_MEMADR, cv(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), 1'b1);
    applyStimulus("a_memrd", S_MEMRD, cv(0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_state", 32'(state_dbg), 32'(S_RESET));
    checkOutput("async_ctl", 32'(obs_ctl), 32'd0);
    checkOutput("async_count", 32'(instr_count), 32'd0);
    exp_count = '0;
    holdReset(2);

    // Seventeen jumps wrap a 4-bit counter back to 1.
    for (int i = 0; i < 17; i++) runInstr(OP_J, 0, 0);
    runInstr(OP_RTYPE, 0, 0);
    checkOutput("wrap_before_exec_retire", 32'(exp_count), 32'd2);

    for (int n = 0; n < 60; n++) begin
      int sel;
      sel = $urandom_range(0, 7);
      if (sel == 7) op = 6'($urandom_range(0, 63));
      else          op = op_list[sel];
      runInstr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    applyStimulus("final_fetch", S_FETCH, cv(1,0,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b1);
    checkOutput("final_count", 32'(instr_count), 32'(exp_count));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multicycle MIPS main control FSM, directly upstream of the ALU control decoder.
- Sequences fetch/decode/execute/memory/writeback per instruction and drives datapath enables and muxes.
- Produces the 2-bit AluOp consumed by the ALU control decoder:
  - 00 = add: address calc, PC+4, branch target, addi.
  - 01 = sub: beq/bne compare.
  - 10 = R-type, funct decides.
- Stalls on a memory ready handshake. Counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Opcode  in  6  IR[31:26]; stable from DECODE until instruction ends
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  conditional PC load (datapath ANDs with branch test)
- BranchNe  out  1  1 = branch on !Zero (bne), 0 = on Zero (beq)
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  out  1
- MemWrite  out  1
- IRWrite  out  1
- MemtoReg  out  1
- RegDst  out  1  1 = rd, 0 = rt
- RegWrite  out  1
- AluSrcA  out  1  0 = PC, 1 = A
- AluSrcB  out  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2
- AluOp  out  2
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  unsupported opcode trap
- state_dbg  out  4  current state
- instr_count  out  CNT_W  retired instructions

Behaviour:
- Single state register, 4 bits, updated on rising clk.
- rst_n low (async):
  - State goes to S_RESET and instr_count to 0.
  - Every output is 0 while in S_RESET.
  - Reset mid-instruction aborts it with no further writes.
- Outputs are a Moore decode of the state, except PCWrite/IRWrite in S_FETCH, which equal mem_ready. Any output not listed for a state is 0.
- States, outputs and transitions:
  - S_RESET: all outputs 0. Next: S_FETCH.
  - S_FETCH: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, AluOp=00, PCSource=00, PCWrite=IRWrite=mem_ready. Holds while !mem_ready; S_DECODE when ready.
  - S_DECODE: AluSrcA=0, AluSrcB=11, AluOp=00 (precompute branch target). Next by Opcode:
    - 100011 lw / 101011 sw / 001000 addi: S_MEMADR.
    - 000000 R-type: S_EXEC.
    - 000100 beq / 000101 bne: S_BRANCH.
    - 000010 j: S_JUMP.
    - anything else: S_TRAP.
  - S_MEMADR: AluSrcA=1, AluSrcB=10, AluOp=00. Next: lw to S_MEMRD, sw to S_MEMWR, addi to S_ADDIWB.
  - S_MEMRD: MemRead=1, IorD=1. Holds until mem_ready, then S_MEMWB.
  - S_MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next: S_FETCH.
  - S_MEMWR: MemWrite=1, IorD=1. Holds until mem_ready, then S_FETCH.
  - S_EXEC: AluSrcA=1, AluSrcB=00, AluOp=10. Next: S_ALUWB.
  - S_ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next: S_FETCH.
  - S_ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next: S_FETCH.
  - S_BRANCH: AluSrcA=1, AluSrcB=00, AluOp=01, PCSource=01, PCWriteCond=1, BranchNe=(Opcode==000101). Next: S_FETCH.
  - S_JUMP: PCSource=10, PCWrite=1. Next: S_FETCH.
  - S_TRAP: illegal_op=1 (exactly one cycle), no writes. Next: S_FETCH.
- MemRead and MemWrite are never both 1. RegWrite is never 1 in the same cycle as MemWrite.
- Unused state encodings go to S_FETCH next cycle with all outputs 0.
- instr_count increments by 1 on the clock edge leaving any of S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP, or S_MEMWR with mem_ready.
  - No increment from S_TRAP or S_RESET.
  - Wraps modulo 2^CNT_W.
- Cycle counts with mem_ready tied 1:
  - lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 3.
  - Each cycle mem_ready is held low in S_FETCH/S_MEMRD/S_MEMWR adds one cycle.

Decomposition:
- Shared header mips_ctrl_defs.vh:
  - State encodings S_*.
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J.
  - AluOp constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10.
  - AluSrcB and PCSource codes.
- The ALU control decoder includes the same AluOp constants.
- No sub-module. Next-state logic, output decode and counter live in one module.

Test Plan:
1. Reset then hold rst_n=0 for 3 cycles -> all outputs 0, state_dbg=S_RESET, instr_count=0. Release -> S_FETCH on next edge.
2. lw (100011), mem_ready=1 -> FETCH, DECODE, MEMADR, MEMRD, MEMWB in 5 cycles. AluOp 00 throughout; RegWrite=1/MemtoReg=1 only in cycle 5; instr_count 0->1.
3. R-type (000000) then beq (000100) -> AluOp=10 in EXEC, RegDst=1 in ALUWB. AluOp=01, PCWriteCond=1, BranchNe=0 in BRANCH. instr_count=2 after 7 cycles.
4. sw with mem_ready low 3 cycles in S_MEMWR -> MemWrite held 4 cycles, IorD=1. Single increment; no RegWrite at any point.
5. Opcode 111111 -> S_TRAP, illegal_op=1 for exactly 1 cycle, no write enables, instr_count unchanged. Then S_FETCH.
6. Assert rst_n=0 asynchronously during S_MEMRD -> outputs 0 immediately, before the next edge. Counter reset to 0. CNT_W=4 run of 17 jumps -> instr_count=1 (wrap).
